// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the riscv memory stage: op, size and cause codes plus FSM states.
package riscv_mem_pkg;

    localparam logic [1:0] OP_PASS  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] CAUSE_LD_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_ST_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_LD_FAULT    = 2'd2;
    localparam logic [1:0] CAUSE_ST_FAULT    = 2'd3;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_REQ  = 2'd1;
    localparam mem_state_t ST_RESP = 2'd2;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/riscv_mem_lsu_if.sv
// EX-side, data-memory and WB-side signals of the memory stage.
interface riscv_mem_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              ex_mem_rdy;
    logic              ex_mem_ack;
    logic [1:0]        ex_mem_op;
    logic [1:0]        ex_mem_size;
    logic              ex_mem_unsigned;
    logic [XLEN-1:0]   ex_mem_addr;
    logic [XLEN-1:0]   ex_mem_wdata;
    logic [XLEN-1:0]   ex_mem_data;
    logic [4:0]        ex_mem_rd;
    logic              dmem_req;
    logic              dmem_gnt;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN/8-1:0] dmem_be;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_err;
    logic              mem_wb_rdy;
    logic              mem_wb_ack;
    logic [XLEN-1:0]   mem_wb_data;
    logic [4:0]        mem_wb_rd;
    logic              mem_wb_exc;
    logic [1:0]        mem_wb_cause;

    modport slave (
        input  ex_mem_rdy, ex_mem_op, ex_mem_size, ex_mem_unsigned, ex_mem_addr,
               ex_mem_wdata, ex_mem_data, ex_mem_rd,
               dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err, mem_wb_ack,
        output ex_mem_ack, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               mem_wb_rdy, mem_wb_data, mem_wb_rd, mem_wb_exc, mem_wb_cause
    );

    modport master (
        output ex_mem_rdy, ex_mem_op, ex_mem_size, ex_mem_unsigned, ex_mem_addr,
               ex_mem_wdata, ex_mem_data, ex_mem_rd,
               dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err, mem_wb_ack,
        input  ex_mem_ack, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               mem_wb_rdy, mem_wb_data, mem_wb_rd, mem_wb_exc, mem_wb_cause
    );
endinterface

// File: rtl/riscv_mem_align.sv
// Byte-lane helpers: misalign check, byte enables and store replication on the request
// side, lane extraction and sign/zero extension on the load-response side.
module riscv_mem_align
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] i_addr_lo,
    input  logic [1:0]                i_size,
    input  logic [XLEN-1:0]           i_wdata,
    input  logic [$clog2(XLEN/8)-1:0] i_ld_addr_lo,
    input  logic [1:0]                i_ld_size,
    input  logic                      i_ld_unsigned,
    input  logic [XLEN-1:0]           i_rdata,
    output logic                      o_misaligned,
    output logic [XLEN/8-1:0]         o_be,
    output logic [XLEN-1:0]           o_wdata,
    output logic [XLEN-1:0]           o_ld_data
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   w_be_base;
    logic [XLEN-1:0] w_lane;
    logic            w_sign;
    int              w_nbits;

    always_comb begin
        case (i_size)
            SZ_B:    o_misaligned = 1'b0;
            SZ_H:    o_misaligned = i_addr_lo[0];
            SZ_W:    o_misaligned = |i_addr_lo[1:0];
            SZ_D:    o_misaligned = (XLEN == 32) ? 1'b1 : (|i_addr_lo);
            default: o_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_be_base = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            w_be_base[i] = (unsigned'(i) < (32'd1 << i_size));
        end
    end

    assign o_be = w_be_base << i_addr_lo;

    // Low 2^size bytes of the store data repeated across every lane
    always_comb begin
        o_wdata = {XLEN{1'b0}};
        for (int j = 0; j < NB; j++) begin
            case (i_size)
                SZ_B:    o_wdata[8*j +: 8] = i_wdata[7:0];
                SZ_H:    o_wdata[8*j +: 8] = i_wdata[8*(j%2) +: 8];
                SZ_W:    o_wdata[8*j +: 8] = i_wdata[8*(j%4) +: 8];
                default: o_wdata[8*j +: 8] = i_wdata[8*j +: 8];
            endcase
        end
    end

    always_comb begin
        w_lane    = i_rdata >> {i_ld_addr_lo, 3'b000};
        o_ld_data = {XLEN{1'b0}};
        case (i_ld_size)
            SZ_B:    begin w_nbits = 8;    w_sign = w_lane[7];  end
            SZ_H:    begin w_nbits = 16;   w_sign = w_lane[15]; end
            SZ_W:    begin w_nbits = 32;   w_sign = w_lane[31]; end
            default: begin w_nbits = XLEN; w_sign = 1'b0;       end
        endcase
        w_sign = w_sign & ~i_ld_unsigned;
        for (int k = 0; k < XLEN; k++) begin
            o_ld_data[k] = (k < w_nbits) ? w_lane[k] : w_sign;
        end
    end

endmodule

// File: rtl/riscv_mem_lsu.sv
// Memory stage between EX and WB: pass-through ops, single-outstanding load/store on a
// req/gnt/rvalid data-memory port, and a one-entry result slot towards WB.
module riscv_mem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rstn,
    riscv_mem_lsu_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

    mem_state_t        r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [NB-1:0]     r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic              r_wb_rdy;
    logic [XLEN-1:0]   r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_wb_exc;
    logic [1:0]        r_wb_cause;

    logic              w_ack;
    logic              w_is_mem;
    logic              w_is_load;
    logic              w_misaligned;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ld_data;

    // Accept only when idle and the slot is empty or draining on this same edge
    assign w_ack     = (r_state == ST_IDLE) && (!r_wb_rdy || bus.mem_wb_ack);
    assign w_is_mem  = is_mem_op(bus.ex_mem_op);
    assign w_is_load = (bus.ex_mem_op == OP_LOAD);

    riscv_mem_align #(.XLEN(XLEN)) u_align (
        .i_addr_lo     (bus.ex_mem_addr[LW-1:0]),
        .i_size        (bus.ex_mem_size),
        .i_wdata       (bus.ex_mem_wdata),
        .i_ld_addr_lo  (r_addr[LW-1:0]),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_rdata       (bus.dmem_rdata),
        .o_misaligned  (w_misaligned),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_ld_data     (w_ld_data)
    );

    assign bus.ex_mem_ack   = w_ack;
    assign bus.dmem_req     = r_req;
    assign bus.dmem_we      = r_we;
    assign bus.dmem_addr    = r_dmem_addr;
    assign bus.dmem_be      = r_be;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.mem_wb_rdy   = r_wb_rdy;
    assign bus.mem_wb_data  = r_wb_data;
    assign bus.mem_wb_rd    = r_wb_rd;
    assign bus.mem_wb_exc   = r_wb_exc;
    assign bus.mem_wb_cause = r_wb_cause;

    // FSM, request latch and output slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_dmem_addr <= {ADDR_W{1'b0}};
            r_be        <= {NB{1'b0}};
            r_wdata     <= {XLEN{1'b0}};
            r_addr      <= {XLEN{1'b0}};
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_rd        <= 5'd0;
            r_wb_rdy    <= 1'b0;
            r_wb_data   <= {XLEN{1'b0}};
            r_wb_rd     <= 5'd0;
            r_wb_exc    <= 1'b0;
            r_wb_cause  <= 2'd0;
        end else begin
            if (r_wb_rdy && bus.mem_wb_ack) begin
                r_wb_rdy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.ex_mem_rdy && w_ack) begin
                        if (w_is_mem && w_misaligned) begin
                            r_wb_rdy   <= 1'b1;
                            r_wb_data  <= bus.ex_mem_addr;
                            r_wb_rd    <= bus.ex_mem_rd;
                            r_wb_exc   <= 1'b1;
                            r_wb_cause <= w_is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                        end else if (w_is_mem) begin
                            r_req       <= 1'b1;
                            r_we        <= !w_is_load;
                            r_dmem_addr <= bus.ex_mem_addr[ADDR_W-1:0] & ~LANE_MASK;
                            r_be        <= w_be;
                            r_wdata     <= w_wdata;
                            r_addr      <= bus.ex_mem_addr;
                            r_size      <= bus.ex_mem_size;
                            r_unsigned  <= bus.ex_mem_unsigned;
                            r_rd        <= bus.ex_mem_rd;
                            r_state     <= ST_REQ;
                        end else begin
                            r_wb_rdy   <= 1'b1;
                            r_wb_data  <= bus.ex_mem_data;
                            r_wb_rd    <= bus.ex_mem_rd;
                            r_wb_exc   <= 1'b0;
                            r_wb_cause <= 2'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.dmem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.dmem_rvalid) begin
                        r_wb_rdy <= 1'b1;
                        r_wb_rd  <= r_rd;
                        r_state  <= ST_IDLE;
                        if (bus.dmem_err) begin
                            r_wb_data  <= r_addr;
                            r_wb_exc   <= 1'b1;
                            r_wb_cause <= r_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                        end else begin
                            r_wb_data  <= r_we ? {XLEN{1'b0}} : w_ld_data;
                            r_wb_exc   <= 1'b0;
                            r_wb_cause <= 2'd0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/riscv_mem_lsu.md
# riscv_mem_lsu

Parametrised memory stage for the riscv pipeline, sitting between EX and WB. Pass-through ops move from EX to WB in one cycle, as before. Load and store ops drive a data-memory port with a req/gnt/rvalid protocol, with:
- byte-lane alignment and load sign/zero extension;
- misalignment detection;
- access-fault reporting.

Only one memory op is outstanding at a time; both pipeline sides use the rdy/ack handshake.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- ADDR_W, 32, dmem address width (≤ XLEN).

Ports (a transfer occurs on any rdy/ack pair only when both are high on a clk edge):
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- ex_mem_rdy  in  1  EX holds a valid op.
- ex_mem_ack  out  1  stage accepts op this cycle.
- ex_mem_op  in  2  0 pass, 1 load, 2 store, 3 reserved (treated as pass).
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only; at XLEN=32 → misaligned exception).
- ex_mem_unsigned  in  1  zero-extend load.
- ex_mem_addr  in  XLEN  effective address.
- ex_mem_wdata  in  XLEN  store data, right-justified.
- ex_mem_data  in  XLEN  ALU result for pass ops.
- ex_mem_rd  in  5  destination register.
- dmem_req  out  1  bus request.
- dmem_gnt  in  1  request accepted.
- dmem_we  out  1  write.
- dmem_addr  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero).
- dmem_be  out  XLEN/8  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rvalid  in  1  response (load data or store completion).
- dmem_rdata  in  XLEN  load data.
- dmem_err  in  1  access fault, qualified by rvalid.
- mem_wb_rdy  out  1  result valid.
- mem_wb_ack  in  1  WB accepts.
- mem_wb_data  out  XLEN  result, or faulting address when exc=1.
- mem_wb_rd  out  5  destination register.
- mem_wb_exc  out  1  exception.
- mem_wb_cause  out  2  0 load misaligned, 1 store misaligned, 2 load fault, 3 store fault.

## Operation
- FSM states:
  - IDLE: may accept from EX.
  - REQ: dmem_req=1, waiting for gnt.
  - RESP: waiting for rvalid.
- Output slot: one register holding mem_wb_rdy/data/rd/exc/cause. mem_wb_rdy stays high, with contents stable, until mem_wb_ack.
- ex_mem_ack = (state==IDLE) && (!mem_wb_rdy || mem_wb_ack).
- Accept of a pass op: slot ← {ex_mem_data, rd, exc=0}; state stays IDLE.
- Accept of a misaligned load/store: slot ← {addr, rd, exc=1, cause 0/1}; no bus activity. A load/store is misaligned when addr is not a multiple of 2^size.
- Accept of an aligned load/store:
  - latch addr, be, wdata, we, size, unsigned, rd;
  - go to REQ.
- REQ: dmem_req and all dmem_* outputs are held stable until gnt. On gnt → RESP.
- RESP, on rvalid:
  - slot written from the response: load → extracted lane, sign- or zero-extended per size/unsigned; store → data 0;
  - if dmem_err → exc=1, cause 2/3, data = latched addr;
  - state → IDLE.
- The slot is always empty at rvalid, because nothing else is accepted while an op is outstanding. rdata is consumed on the rvalid cycle.
- dmem_be: 2^size consecutive ones starting at lane addr[log2(XLEN/8)-1:0].
- dmem_wdata: low 2^size bytes of wdata replicated across all lanes.
- rvalid outside RESP and gnt outside REQ are ignored.

## Timing
- Reset values:
  - state IDLE;
  - dmem_req, dmem_we, mem_wb_rdy, mem_wb_exc = 0;
  - all data/address/be/rd/cause outputs = 0.
- Pass op: accepted on cycle N; mem_wb_rdy at N+1. Sustains 1 op/cycle while WB acks.
- Load/store, zero-wait memory: accept N; req N+1 (gnt at N+1); rvalid N+2; mem_wb_rdy N+3. Minimum 3 cycles per memory op.
- WB stall (mem_wb_rdy && !mem_wb_ack): ex_mem_ack=0 the same cycle. Release is combinational: slot drain and new accept happen on the same edge.
- Reset mid-operation: dmem_req drops immediately and the op is discarded; the memory side shares rstn.

## Structure
- Package riscv_mem_pkg holds:
  - op codes (OP_PASS/LOAD/STORE);
  - size codes;
  - cause codes;
  - FSM state enum.
- Sub-module riscv_mem_align (combinational, XLEN-parametrised) implements:
  - misalign check;
  - be generation;
  - store replication;
  - load lane extract/extend.
- riscv_mem_lsu holds the FSM, the request latch and the output slot.

## Test plan
- Back-to-back pass ops 0x11, 0x22, 0x33, with WB acking every other cycle → each value appears once, in order, held while unacked; ex_mem_ack low during stalls.
- Signed byte load, addr 0x1003, rdata 0x80000000 → dmem_addr 0x1000, be 1000, mem_wb_data 0xFFFFFF80. Same op with unsigned=1 → 0x00000080.
- Half store at 0x102, wdata 0x1234ABCD → dmem_we 1, be 1100, dmem_wdata 0xABCDABCD, mem_wb_exc 0.
- Word load at 0x101 → no dmem_req, mem_wb_exc 1, cause 0, data 0x101, one cycle after accept.
- gnt delayed 3 cycles, then rvalid with dmem_err on a store to 0x200 → dmem_* outputs stable through REQ; result exc 1, cause 3, data 0x200. XLEN=64 dword load at 0x8 → be 0xFF.
- rstn asserted during RESP → dmem_req and mem_wb_rdy go to 0 asynchronously; after release, a pass op completes normally.
